// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port RAM between the core's instruction-fetch port (I) and
// its load/store port (D). One memory access is issued per grant. Reads park
// the arbiter in S_WAIT until the data returns, and the data is routed only to
// the port that issued the read.
//
// Arbitration: D beats I. The exception is when I has lost MAX_DATA_STREAK
// contended grants in a row; then I wins once and the streak clears.
//
// Parameters
//   READ_LATENCY     cycles from m_r_enable to valid m_rdata (1..15)
//   MAX_DATA_STREAK  contended D grants allowed before a pending I wins (1..15)
//
// Ports
//   clk, reset_n                         clock, synchronous active-low reset
//   i_req/i_addr -> i_gnt                fetch request / accept
//   i_rvalid/i_rdata                     fetch data return (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata/d_wstrb    load/store request
//   d_gnt                                load/store accept
//   d_rvalid/d_rdata                     load data return (1-cycle pulse)
//   m_addr/m_r_enable/m_w_enable         memory command
//   m_wdata/m_wstrb                      memory write data / byte enables
//   m_rdata                              memory read data
//
// Grants and the memory command are combinational in the grant cycle. While
// reset_n is low every output is held at 0, so nothing leaks to the memory or
// to the core during reset.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,

  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,

  output logic [31:0] m_addr,
  output logic        m_r_enable,
  output logic        m_w_enable,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] RD_LAT = 4'(READ_LATENCY);
  localparam logic [3:0] STREAK = 4'(MAX_DATA_STREAK);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  state_e     state_q;
  logic [3:0] streak_q;   // contended D grants since I last won
  logic [3:0] lat_cnt_q;  // cycles left until m_rdata is valid
  logic       own_d_q;    // 1: outstanding read belongs to D, 0: to I

  // ---------------------------------------------------------------------------
  // Grant selection (combinational, IDLE only)
  // ---------------------------------------------------------------------------
  logic can_gnt;
  logic gnt_i;
  logic gnt_d;
  logic rd_done;

  assign can_gnt = reset_n && (state_q == S_IDLE);

  // I wins when alone, or when D has used up its streak allowance.
  assign gnt_i = can_gnt && i_req && (!d_req || (streak_q == STREAK));
  assign gnt_d = can_gnt && d_req && !gnt_i;

  assign i_gnt = gnt_i;
  assign d_gnt = gnt_d;

  // ---------------------------------------------------------------------------
  // Memory command, driven only in the grant cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    m_addr     = 32'h0;
    m_wdata    = 32'h0;
    m_wstrb    = 4'h0;
    m_r_enable = 1'b0;
    m_w_enable = 1'b0;
    if (gnt_i) begin
      // Fetches are always reads; there is no write data to forward.
      m_addr     = i_addr;
      m_r_enable = 1'b1;
    end else if (gnt_d) begin
      m_addr     = d_addr;
      m_wdata    = d_wdata;
      m_wstrb    = d_wstrb;
      m_r_enable = !d_we;
      m_w_enable = d_we;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return: last WAIT cycle, steered to the owner only
  // ---------------------------------------------------------------------------
  assign rd_done  = reset_n && (state_q == S_WAIT) && (lat_cnt_q == 4'd1);
  assign i_rvalid = rd_done && !own_d_q;
  assign d_rvalid = rd_done &&  own_d_q;
  // Gate rdata so the idle value is a clean 0 rather than whatever the RAM
  // happens to drive.
  assign i_rdata  = i_rvalid ? m_rdata : 32'h0;
  assign d_rdata  = d_rvalid ? m_rdata : 32'h0;

  // ---------------------------------------------------------------------------
  // State, streak and latency tracking
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Drops any outstanding read: the counter and owner are cleared, so a
      // late m_rdata has no path to either port.
      state_q   <= S_IDLE;
      streak_q  <= 4'd0;
      lat_cnt_q <= 4'd0;
      own_d_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_i) begin
            streak_q  <= 4'd0;
            own_d_q   <= 1'b0;
            lat_cnt_q <= RD_LAT;
            state_q   <= S_WAIT;
          end else if (gnt_d) begin
            // Only contended D grants count toward starving I; the counter
            // saturates so it always equals STREAK once the limit is hit.
            if (i_req && (streak_q != STREAK))
              streak_q <= streak_q + 4'd1;
            if (!d_we) begin
              own_d_q   <= 1'b1;
              lat_cnt_q <= RD_LAT;
              state_q   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiters with independent stimulus: index 0 uses READ_LATENCY=1 and
// index 1 uses READ_LATENCY=3. Both use MAX_DATA_STREAK=4. Inputs are driven
// 1 time unit after the rising edge. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_n;
  logic [1:0]        i_req, i_gnt, i_rvalid;
  logic [1:0][31:0]  i_addr, i_rdata;
  logic [1:0]        d_req, d_we, d_gnt, d_rvalid;
  logic [1:0][31:0]  d_addr, d_wdata, d_rdata;
  logic [1:0][3:0]   d_wstrb, m_wstrb;
  logic [1:0][31:0]  m_addr, m_wdata, m_rdata;
  logic [1:0]        m_r_enable, m_w_enable;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .READ_LATENCY   ((g == 0) ? 1 : 3),
      .MAX_DATA_STREAK(4)
    ) u_dut (
      .clk        (clk),
      .reset_n    (rst_n[g]),
      .i_req      (i_req[g]),
      .i_addr     (i_addr[g]),
      .i_gnt      (i_gnt[g]),
      .i_rvalid   (i_rvalid[g]),
      .i_rdata    (i_rdata[g]),
      .d_req      (d_req[g]),
      .d_we       (d_we[g]),
      .d_addr     (d_addr[g]),
      .d_wdata    (d_wdata[g]),
      .d_wstrb    (d_wstrb[g]),
      .d_gnt      (d_gnt[g]),
      .d_rvalid   (d_rvalid[g]),
      .d_rdata    (d_rdata[g]),
      .m_addr     (m_addr[g]),
      .m_r_enable (m_r_enable[g]),
      .m_w_enable (m_w_enable[g]),
      .m_wdata    (m_wdata[g]),
      .m_wstrb    (m_wstrb[g]),
      .m_rdata    (m_rdata[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every output is expected to be 0 (reset value / no activity).
  task automatic chk_quiet(input int g, input string tag);
    chk({tag, " i_gnt"},      32'(i_gnt[g]),      32'h0);
    chk({tag, " d_gnt"},      32'(d_gnt[g]),      32'h0);
    chk({tag, " i_rvalid"},   32'(i_rvalid[g]),   32'h0);
    chk({tag, " d_rvalid"},   32'(d_rvalid[g]),   32'h0);
    chk({tag, " m_r_enable"}, 32'(m_r_enable[g]), 32'h0);
    chk({tag, " m_w_enable"}, 32'(m_w_enable[g]), 32'h0);
    chk({tag, " m_wstrb"},    32'(m_wstrb[g]),    32'h0);
    chk({tag, " m_addr"},     m_addr[g],          32'h0);
    chk({tag, " m_wdata"},    m_wdata[g],         32'h0);
    chk({tag, " i_rdata"},    i_rdata[g],         32'h0);
    chk({tag, " d_rdata"},    d_rdata[g],         32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = '0; i_req = '0; i_addr = '0; d_req = '0; d_we = '0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0; m_rdata = '0;

    // ---- reset values ----
    cyc(); cyc();
    smp();
    chk_quiet(0, "rst0");
    chk_quiet(1, "rst1");

    // ---- reset exit with both requesting: data wins ----
    cyc();
    rst_n = 2'b11;
    i_req[0] = 1'b1; i_addr[0] = 32'h80;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h200;
    d_wdata[0] = 32'h11223344; d_wstrb[0] = 4'hF;
    smp();
    chk("exit d_gnt",      32'(d_gnt[0]),      32'h1);
    chk("exit i_gnt",      32'(i_gnt[0]),      32'h0);
    chk("exit m_w_enable", 32'(m_w_enable[0]), 32'h1);
    chk("exit m_addr",     m_addr[0],          32'h200);

    // store done, fetch is now alone
    cyc();
    d_req[0] = 1'b0;
    smp();
    chk("exitf i_gnt",  32'(i_gnt[0]),      32'h1);
    chk("exitf m_ren",  32'(m_r_enable[0]), 32'h1);
    chk("exitf m_addr", m_addr[0],          32'h80);
    cyc();
    i_req[0] = 1'b0; m_rdata[0] = 32'hCAFEF00D;
    smp();
    chk("exitf i_rvalid", 32'(i_rvalid[0]), 32'h1);
    chk("exitf i_rdata",  i_rdata[0],       32'hCAFEF00D);
    chk("exitf d_rvalid", 32'(d_rvalid[0]), 32'h0);

    // ---- lone fetch, READ_LATENCY=1 ----
    cyc();
    i_req[0] = 1'b1; i_addr[0] = 32'h40; m_rdata[0] = 32'h0;
    smp();
    chk("fetch i_gnt",   32'(i_gnt[0]),      32'h1);
    chk("fetch m_ren",   32'(m_r_enable[0]), 32'h1);
    chk("fetch m_addr",  m_addr[0],          32'h40);
    chk("fetch m_wstrb", 32'(m_wstrb[0]),    32'h0);
    cyc();
    i_req[0] = 1'b0; m_rdata[0] = 32'hDEADBEEF;
    smp();
    chk("fetch i_rvalid", 32'(i_rvalid[0]), 32'h1);
    chk("fetch i_rdata",  i_rdata[0],       32'hDEADBEEF);
    chk("fetch d_rvalid", 32'(d_rvalid[0]), 32'h0);
    chk("fetch d_rdata",  d_rdata[0],       32'h0);

    // ---- store then load back-to-back ----
    cyc();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h100;
    d_wdata[0] = 32'hA5A50001; d_wstrb[0] = 4'h3; m_rdata[0] = 32'h0;
    smp();
    chk("st d_gnt",   32'(d_gnt[0]),      32'h1);
    chk("st m_wen",   32'(m_w_enable[0]), 32'h1);
    chk("st m_ren",   32'(m_r_enable[0]), 32'h0);
    chk("st m_wstrb", 32'(m_wstrb[0]),    32'h3);
    chk("st m_wdata", m_wdata[0],         32'hA5A50001);
    chk("st m_addr",  m_addr[0],          32'h100);
    cyc();
    d_we[0] = 1'b0;
    smp();
    chk("ld d_gnt",  32'(d_gnt[0]),      32'h1);
    chk("ld m_ren",  32'(m_r_enable[0]), 32'h1);
    chk("ld m_wen",  32'(m_w_enable[0]), 32'h0);
    chk("ld m_addr", m_addr[0],          32'h100);
    cyc();
    d_req[0] = 1'b0; m_rdata[0] = 32'h0000BEEF;
    smp();
    chk("ld d_rvalid", 32'(d_rvalid[0]), 32'h1);
    chk("ld d_rdata",  d_rdata[0],       32'h0000BEEF);
    chk("ld i_rvalid", 32'(i_rvalid[0]), 32'h0);

    // ---- starvation guard: 4 data grants, then the fetch ----
    cyc();
    i_req[0] = 1'b1; i_addr[0] = 32'h44;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h300; d_wstrb[0] = 4'hF;
    m_rdata[0] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) cyc();
      smp();
      chk($sformatf("stv d_gnt%0d", k), 32'(d_gnt[0]), 32'h1);
      chk($sformatf("stv i_gnt%0d", k), 32'(i_gnt[0]), 32'h0);
    end
    cyc();
    smp();
    chk("stv5 i_gnt",  32'(i_gnt[0]), 32'h1);
    chk("stv5 d_gnt",  32'(d_gnt[0]), 32'h0);
    chk("stv5 m_addr", m_addr[0],     32'h44);
    cyc();
    m_rdata[0] = 32'h5555AAAA;
    smp();
    chk("stvw i_rvalid", 32'(i_rvalid[0]), 32'h1);
    chk("stvw d_gnt",    32'(d_gnt[0]),    32'h0);
    // streak cleared: another 4 data grants before the fetch wins again
    m_rdata[0] = 32'h0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      smp();
      chk($sformatf("stv2 d_gnt%0d", k), 32'(d_gnt[0]), 32'h1);
    end
    cyc();
    smp();
    chk("stv2 i_gnt", 32'(i_gnt[0]), 32'h1);
    cyc();
    i_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;

    // ---- fetch request withdrawn during WAIT ----
    cyc();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h20;
    smp();
    chk("wd d_gnt", 32'(d_gnt[0]), 32'h1);
    cyc();
    d_req[0] = 1'b0; i_req[0] = 1'b1; i_addr[0] = 32'h60;
    smp();
    chk("wd wait i_gnt", 32'(i_gnt[0]),    32'h0);
    chk("wd d_rvalid",   32'(d_rvalid[0]), 32'h1);
    cyc();
    i_req[0] = 1'b0;
    smp();
    chk("wd i_gnt", 32'(i_gnt[0]),      32'h0);
    chk("wd m_ren", 32'(m_r_enable[0]), 32'h0);
    cyc();
    smp();
    chk("wd m_ren2",    32'(m_r_enable[0]), 32'h0);
    chk("wd i_rvalid",  32'(i_rvalid[0]),   32'h0);

    // ---- READ_LATENCY=3: load, fetch pending during WAIT ----
    cyc();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h500;
    smp();
    chk("rl3 d_gnt", 32'(d_gnt[1]),      32'h1);
    chk("rl3 m_ren", 32'(m_r_enable[1]), 32'h1);
    cyc();
    d_req[1] = 1'b0; i_req[1] = 1'b1; i_addr[1] = 32'h600;
    smp();
    chk("rl3 T1 i_gnt",    32'(i_gnt[1]),      32'h0);
    chk("rl3 T1 m_ren",    32'(m_r_enable[1]), 32'h0);
    chk("rl3 T1 d_rvalid", 32'(d_rvalid[1]),   32'h0);
    cyc();
    smp();
    chk("rl3 T2 i_gnt",    32'(i_gnt[1]),    32'h0);
    chk("rl3 T2 d_rvalid", 32'(d_rvalid[1]), 32'h0);
    cyc();
    m_rdata[1] = 32'h12345678;
    smp();
    chk("rl3 T3 d_rvalid", 32'(d_rvalid[1]), 32'h1);
    chk("rl3 T3 d_rdata",  d_rdata[1],       32'h12345678);
    chk("rl3 T3 i_gnt",    32'(i_gnt[1]),    32'h0);
    chk("rl3 T3 i_rvalid", 32'(i_rvalid[1]), 32'h0);
    cyc();
    m_rdata[1] = 32'h0;
    smp();
    chk("rl3 T4 i_gnt",  32'(i_gnt[1]), 32'h1);
    chk("rl3 T4 m_addr", m_addr[1],     32'h600);
    cyc();
    i_req[1] = 1'b0;
    cyc();
    cyc();
    m_rdata[1] = 32'h87654321;
    smp();
    chk("rl3 f i_rvalid", 32'(i_rvalid[1]), 32'h1);
    chk("rl3 f i_rdata",  i_rdata[1],       32'h87654321);
    chk("rl3 f d_rvalid", 32'(d_rvalid[1]), 32'h0);

    // ---- reset during WAIT abandons the read ----
    cyc();
    m_rdata[1] = 32'h0;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'h700;
    smp();
    chk("mrst d_gnt", 32'(d_gnt[1]), 32'h1);
    cyc();
    d_req[1] = 1'b0; rst_n[1] = 1'b0;
    smp();
    chk("mrst T1 d_rvalid", 32'(d_rvalid[1]), 32'h0);
    cyc();
    rst_n[1] = 1'b1; m_rdata[1] = 32'hBADBAD00;
    smp();
    chk_quiet(1, "mrst T2");
    for (int k = 0; k < 5; k++) begin
      cyc();
      smp();
      chk($sformatf("mrst d_rvalid+%0d", k), 32'(d_rvalid[1]), 32'h0);
      chk($sformatf("mrst i_rvalid+%0d", k), 32'(i_rvalid[1]), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port memory between the core's instruction-fetch port and its load/store data port, so the core can run from one unified RAM instead of a separate ROM. It sits between the core and the memory. Each grant issues exactly one memory access, and read data is returned only to the requester that owns it. Data accesses have priority over fetches, and a streak limit prevents fetch starvation.

## Interface
Parameters:
- READ_LATENCY, 1: cycles from the read-enable cycle to valid `m_rdata`; legal range 1..15.
- MAX_DATA_STREAK, 4: consecutive data grants allowed while a fetch is pending before the fetch wins; legal range 1..15.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous active-low reset
- i_req  in  1  fetch request; held with `i_addr` stable until `i_gnt`
- i_addr  in  32  fetch address
- i_gnt  out  1  fetch accepted this cycle
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  32  fetch data, meaningful only with `i_rvalid`
- d_req  in  1  data request; held with `d_*` stable until `d_gnt`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid (1-cycle pulse)
- d_rdata  out  32  load data, meaningful only with `d_rvalid`
- m_addr  out  32  memory address
- m_r_enable  out  1  memory read strobe
- m_w_enable  out  1  memory write strobe
- m_wdata  out  32  memory write data
- m_wstrb  out  4  memory byte enables
- m_rdata  in  32  memory read data

## Operation
States:
- IDLE: arbiter may grant.
- WAIT: a read is outstanding; no grant is possible in this state.

Grant rule in IDLE (combinational; one grant at most per cycle):
- Only `d_req` asserted: grant data.
- Only `i_req` asserted: grant instruction.
- Both asserted: grant data, unless `streak == MAX_DATA_STREAK`; in that case grant instruction.

`streak` (4-bit counter):
- Increments on a data grant issued while `i_req` = 1, saturating at MAX_DATA_STREAK.
- Clears on any instruction grant.
- Holds on a data grant with `i_req` = 0.

Grant cycle:
- The arbiter drives `m_addr`, `m_wdata` and `m_wstrb` from the winner in the same cycle.
- It pulses `m_r_enable` for a fetch or a load, or `m_w_enable` for a store.
- Instruction fetches are always reads.

After the grant cycle:
- Store: stays in IDLE; a new grant is possible next cycle.
- Read: latches the owner (I or D), loads `lat_cnt` = READ_LATENCY, and moves to WAIT.

WAIT:
- `lat_cnt` decrements each cycle.
- On the cycle `lat_cnt` reaches 1: pulse the owner's `rvalid`, route `m_rdata` to the owner's `rdata`, then return to IDLE.

Outputs outside the grant cycle:
- `m_r_enable`, `m_w_enable`, `m_wstrb` = 0.
- `m_addr` and `m_wdata` are don't-care; implement as 0.

Other rules:
- A requester may drop `req` before it is granted; nothing is issued for it.
- A non-owner's `rvalid` is never asserted.

## Timing
Reset values (all outputs):
- `i_gnt`, `d_gnt`, `i_rvalid`, `d_rvalid`, `m_r_enable`, `m_w_enable` = 0.
- `m_wstrb` = 0; `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
- State = IDLE, `streak` = 0, `lat_cnt` = 0.

Latencies:
- Read granted at cycle T: `rvalid` at T+READ_LATENCY; earliest next grant at T+READ_LATENCY+1.
- Store granted at T: earliest next grant at T+1.
- Grants are combinational in IDLE: a request arriving at T with no contention is granted at T.

Boundary conditions:
- Reset asserted during WAIT: abandon the outstanding read. The owner receives no `rvalid`, then or later; `m_rdata` arriving later is ignored.
- Request rising during WAIT: held pending; it is granted on the cycle after `rvalid`.
- Simultaneous requests at reset exit: data wins (`streak` = 0).

## Test plan
- Lone fetch, READ_LATENCY=1: `i_req`, `i_addr`=0x40 at T -> `i_gnt`, `m_r_enable`, `m_addr`=0x40 at T; `i_rvalid`, `i_rdata`=`m_rdata` (0xDEADBEEF) at T+1; `d_rvalid` stays 0.
- Store then load back-to-back: store 0x100, `d_wstrb`=0x3 at T -> `m_w_enable`, `m_wstrb`=0x3 at T; load granted at T+1; `d_rvalid` at T+1+READ_LATENCY.
- Starvation guard, MAX_DATA_STREAK=4, READ_LATENCY=1, `i_req` held high, stores continuous -> 4 data grants, then `i_gnt` on the 5th grant cycle; `streak` returns to 0.
- READ_LATENCY=3, load at T with `i_req` raised at T+1 -> no grants T+1..T+3; `d_rvalid` at T+3; `i_gnt` at T+4.
- Reset mid-read, READ_LATENCY=3: `reset_n`=0 at T+1 -> all outputs 0 at T+2; no `rvalid` in the following 5 cycles.
- Request withdrawn: `i_req` high for 1 cycle during WAIT, then low -> no fetch is issued.
